// File: rtl/id_pipe_pkg.sv
// Shared decode constants and bundle layout for the id_pipe decode stage.
package id_pipe_pkg;

  localparam int OPC_W = 7;
  localparam int REG_W = 5;
  localparam int F3_W  = 3;
  localparam int F7_W  = 7;
  localparam int CSR_W = 12;

  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
  localparam logic [6:0] INST_TYPE_L   = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S   = 7'b0100011;
  localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_JAL      = 7'b1101111;
  localparam logic [6:0] INST_JALR     = 7'b1100111;
  localparam logic [6:0] INST_LUI      = 7'b0110111;
  localparam logic [6:0] INST_AUIPC    = 7'b0010111;
  localparam logic [6:0] INST_CSR      = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RSVD = 3'b100;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  localparam logic [5:0] SH_ALT    = 6'h10;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [CSR_W-1:0] csr;
    logic             rd_we;
    logic             rs1_re;
    logic             rs2_re;
    logic             illegal;
  } dec_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/id_decode.sv
// Combinational RISC-V instruction decoder feeding the id_pipe registers.
// Define ID_RV_M_EN to accept the M-extension OP encodings.
module id_decode
  import id_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);

`ifdef ID_RV_M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_i, is_l, is_s, is_b, is_r;
  logic is_jal, is_jalr, is_lui, is_auipc, is_sys;
  logic shift, sh_ok, r_ok, ld_ok, st_ok;
  logic legal, rdw, r1, r2;
  logic [31:0] imm32;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  assign is_i     = opc == INST_TYPE_I;
  assign is_l     = opc == INST_TYPE_L;
  assign is_s     = opc == INST_TYPE_S;
  assign is_b     = opc == INST_TYPE_B;
  assign is_r     = opc == INST_TYPE_R_M;
  assign is_jal   = opc == INST_JAL;
  assign is_jalr  = opc == INST_JALR;
  assign is_lui   = opc == INST_LUI;
  assign is_auipc = opc == INST_AUIPC;
  assign is_sys   = opc == INST_CSR;

  assign shift = is_i && (f3 == F3_SLL || f3 == F3_SRL);
  // inst[25] is shamt[5] on RV64 and must be clear on RV32
  assign sh_ok = (inst_i[31:26] == 6'h0 ||
                  (inst_i[31:26] == SH_ALT && f3 == F3_SRL)) &&
                 !(XLEN == 32 && inst_i[25]);
  assign r_ok = f7 == F7_BASE ||
                (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL)) ||
                (M_EN && f7 == F7_MULDIV);
  assign ld_ok = f3 != 3'b111 &&
                 (XLEN == 64 || (f3 != 3'b011 && f3 != 3'b110));
  assign st_ok = f3[2] == 1'b0 && (XLEN == 64 || f3 != 3'b011);

  always_comb begin
    legal = 1'b0;
    rdw   = 1'b0;
    r1    = 1'b0;
    r2    = 1'b0;
    imm32 = '0;
    unique case (1'b1)
      is_i: begin
        legal = shift ? sh_ok : 1'b1;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        r1 = 1'b1;
        rdw = 1'b1;
      end
      is_l: begin
        legal = ld_ok;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        r1 = 1'b1;
        rdw = 1'b1;
      end
      is_s: begin
        legal = st_ok;
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        r1 = 1'b1;
        r2 = 1'b1;
      end
      is_b: begin
        legal = f3[2:1] != 2'b01;
        imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                 inst_i[11:8], 1'b0};
        r1 = 1'b1;
        r2 = 1'b1;
      end
      is_r: begin
        legal = r_ok;
        r1 = 1'b1;
        r2 = 1'b1;
        rdw = 1'b1;
      end
      is_jal: begin
        legal = 1'b1;
        imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                 inst_i[30:21], 1'b0};
        rdw = 1'b1;
      end
      is_jalr: begin
        legal = f3 == F3_ADD;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        r1 = 1'b1;
        rdw = 1'b1;
      end
      is_lui, is_auipc: begin
        legal = 1'b1;
        imm32 = {inst_i[31:12], 12'h0};
        rdw = 1'b1;
      end
      is_sys: begin
        legal = f3 != F3_RSVD;
        imm32 = f3[2] ? {27'h0, inst_i[19:15]}
                      : {{20{inst_i[31]}}, inst_i[31:20]};
        r1 = !f3[2] && f3 != F3_PRIV;
        rdw = f3 != F3_PRIV;
      end
      default: ;
    endcase
    if (inst_i[1:0] != 2'b11) legal = 1'b0;
  end

  always_comb begin
    dec_o.opcode  = opc;
    dec_o.rd      = inst_i[11:7];
    dec_o.rs1     = inst_i[19:15];
    dec_o.rs2     = inst_i[24:20];
    dec_o.funct3  = (is_lui || is_auipc || is_jal) ? 3'h0 : f3;
    dec_o.funct7  = (is_r || shift) ? f7 : 7'h0;
    dec_o.csr     = is_sys ? inst_i[31:20] : 12'h0;
    dec_o.rd_we   = legal && rdw && (inst_i[11:7] != 5'd0);
    dec_o.rs1_re  = legal && r1;
    dec_o.rs2_re  = legal && r2;
    dec_o.illegal = !legal;
    imm_o = legal ? XLEN'($signed(imm32)) : '0;
  end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage with 2-entry skid buffer and flush.
// Optional M-extension decode is enabled by defining ID_RV_M_EN.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [31:0]     in_inst_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [6:0]      out_opcode_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [2:0]      out_funct3_o,
  output logic [6:0]      out_funct7_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [11:0]     out_csr_addr_o,
  output logic            out_rd_we_o,
  output logic            out_rs1_re_o,
  output logic            out_rs2_re_o,
  output logic            out_illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_t            dec;
  } ent_t;

  dec_t            dec;
  logic [XLEN-1:0] dimm;
  ent_t            in_ent, main_q, main_d, skid_q;
  state_e          state_q, state_d;
  logic            valid_q, ready_q;
  logic            acc, pop, ld_main, ld_skid, from_skid;

  id_decode #(.XLEN(XLEN)) u_dec (
    .inst_i (in_inst_i),
    .dec_o  (dec),
    .imm_o  (dimm)
  );

  assign in_ent = '{pc: in_pc_i, imm: dimm, dec: dec};
  assign acc    = in_valid_i && ready_q;
  assign pop    = valid_q && out_ready_i;
  assign main_d = from_skid ? skid_q : in_ent;

  always_comb begin
    state_d   = state_q;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (acc) begin
          state_d = ONE;
          ld_main = 1'b1;
        end
        ONE: if (acc && pop) begin
          ld_main = 1'b1;
        end else if (acc) begin
          state_d = FULL;
          ld_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
        FULL: if (pop) begin
          state_d   = ONE;
          ld_main   = 1'b1;
          from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= state_d != EMPTY;
      ready_q <= state_d != FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_PC_ZERO) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (ld_main) main_q <= main_d;
      if (ld_skid) skid_q <= in_ent;
    end
  end

  assign in_ready_o     = ready_q;
  assign out_valid_o    = valid_q;
  assign out_pc_o       = main_q.pc;
  assign out_imm_o      = main_q.imm;
  assign out_opcode_o   = main_q.dec.opcode;
  assign out_rd_o       = main_q.dec.rd;
  assign out_rs1_o      = main_q.dec.rs1;
  assign out_rs2_o      = main_q.dec.rs2;
  assign out_funct3_o   = main_q.dec.funct3;
  assign out_funct7_o   = main_q.dec.funct7;
  assign out_csr_addr_o = main_q.dec.csr;
  assign out_rd_we_o    = main_q.dec.rd_we;
  assign out_rs1_re_o   = main_q.dec.rs1_re;
  assign out_rs2_re_o   = main_q.dec.rs2_re;
  assign out_illegal_o  = main_q.dec.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_id_pipe;

`ifdef ID_RV_M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [11:0] csr;
    logic        we;
    logic        r1;
    logic        r2;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } item_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [63:0] pc;
  logic [31:0] inst;

  logic        v32, r32, we32, a32, b32, ill32;
  logic [31:0] pc32, imm32;
  logic [6:0]  opc32, f7_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [11:0] csr32;

  logic        v64, r64, we64, a64, b64, ill64;
  logic [63:0] pc64, imm64;
  logic [6:0]  opc64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [11:0] csr64;

  exp_t act32, act64;
  int nvec = 0;
  int nerr = 0;
  item_t q[$];
  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h33,
                           7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};

  assign act32 = {32'h0, pc32, opc32, rd32, rs1_32, rs2_32, f3_32,
                  f7_32, 32'h0, imm32, csr32, we32, a32, b32, ill32};
  assign act64 = {pc64, opc64, rd64, rs1_64, rs2_64, f3_64,
                  f7_64, imm64, csr64, we64, a64, b64, ill64};

  always #5 clk = ~clk;

  id_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(r32),
    .in_pc_i(pc[31:0]), .in_inst_i(inst),
    .out_valid_o(v32), .out_ready_i(out_ready),
    .out_pc_o(pc32), .out_opcode_o(opc32), .out_rd_o(rd32),
    .out_rs1_o(rs1_32), .out_rs2_o(rs2_32), .out_funct3_o(f3_32),
    .out_funct7_o(f7_32), .out_imm_o(imm32), .out_csr_addr_o(csr32),
    .out_rd_we_o(we32), .out_rs1_re_o(a32), .out_rs2_re_o(b32),
    .out_illegal_o(ill32)
  );

  id_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(r64),
    .in_pc_i(pc), .in_inst_i(inst),
    .out_valid_o(v64), .out_ready_i(out_ready),
    .out_pc_o(pc64), .out_opcode_o(opc64), .out_rd_o(rd64),
    .out_rs1_o(rs1_64), .out_rs2_o(rs2_64), .out_funct3_o(f3_64),
    .out_funct7_o(f7_64), .out_imm_o(imm64), .out_csr_addr_o(csr64),
    .out_rd_we_o(we64), .out_rs1_re_o(a64), .out_rs2_re_o(b64),
    .out_illegal_o(ill64)
  );

  // Reference decode written from the ISA format tables.
  function automatic exp_t model(input logic [63:0] p,
                                 input logic [31:0] i, input int xlen);
    exp_t e;
    logic [2:0] f3;
    logic [63:0] im_i, im;
    bit ok, sh, rdw, r1, r2;
    f3 = i[14:12];
    im_i = {{52{i[31]}}, i[31:20]};
    e = '0;
    ok = 0; rdw = 0; r1 = 0; r2 = 0; im = '0;
    e.pc = (xlen == 32) ? {32'h0, p[31:0]} : p;
    e.opc = i[6:0];
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.f3 = f3;
    case (i[6:0])
      7'h13: begin
        sh = (f3 == 1) || (f3 == 5);
        e.f7 = sh ? i[31:25] : 7'h0;
        if (!sh) ok = 1;
        else if (f3 == 1) ok = (i[31:26] == 0);
        else ok = (i[31:26] == 0) || (i[31:26] == 6'h10);
        if (sh && xlen == 32 && i[25]) ok = 0;
        im = im_i; r1 = 1; rdw = 1;
      end
      7'h03: begin
        ok = (f3 != 7) && (xlen == 64 || (f3 != 3 && f3 != 6));
        im = im_i; r1 = 1; rdw = 1;
      end
      7'h23: begin
        ok = (f3 < 3) || (xlen == 64 && f3 == 3);
        im = {{52{i[31]}}, i[31:25], i[11:7]}; r1 = 1; r2 = 1;
      end
      7'h63: begin
        ok = (f3 != 2) && (f3 != 3);
        im = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        r1 = 1; r2 = 1;
      end
      7'h33: begin
        e.f7 = i[31:25];
        ok = (i[31:25] == 0) ||
             (i[31:25] == 7'h20 && (f3 == 0 || f3 == 5)) ||
             (M_EN && i[31:25] == 7'h01);
        r1 = 1; r2 = 1; rdw = 1;
      end
      7'h6f: begin
        ok = 1; e.f3 = 0; rdw = 1;
        im = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h67: begin
        ok = (f3 == 0); im = im_i; r1 = 1; rdw = 1;
      end
      7'h37, 7'h17: begin
        ok = 1; e.f3 = 0; rdw = 1;
        im = {{32{i[31]}}, i[31:12], 12'h0};
      end
      7'h73: begin
        e.csr = i[31:20];
        ok = (f3 != 4);
        im = (f3 >= 4) ? {59'h0, i[19:15]} : im_i;
        r1 = (f3 >= 1) && (f3 <= 3);
        rdw = (f3 != 0);
      end
      default: ok = 0;
    endcase
    if (!ok) begin im = '0; rdw = 0; r1 = 0; r2 = 0; end
    if (i[11:7] == 0) rdw = 0;
    if (xlen == 32) im[63:32] = '0;
    e.imm = im; e.we = rdw; e.r1 = r1; e.r2 = r2; e.ill = !ok;
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    int k;
    k = $urandom_range(0, 12);
    i = $urandom;
    if (k < 10) i[6:0] = ops[k];
    if (k == 4 && $urandom_range(0, 2) != 0)
      i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h01;
    if (k == 0 && $urandom_range(0, 1) != 0)
      i[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
    return i;
  endfunction

  task automatic offer(input logic [63:0] p, input logic [31:0] i);
    pc = p; inst = i; in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; flush = 1; in_valid = 1; out_ready = 1;
    pc = 64'h40; inst = 32'h00100093;
    repeat (3) @(negedge clk);
    rst = 0; flush = 0; in_valid = 0;
    nvec++;
    if ({v32, r32} !== 2'b01) begin
      nerr++; $display("FAIL reset_hs32: got %b want 01", {v32, r32});
    end
    nvec++;
    if ({v64, r64} !== 2'b01) begin
      nerr++; $display("FAIL reset_hs64: got %b want 01", {v64, r64});
    end
    nvec++;
    if (act32 !== '0) begin
      nerr++; $display("FAIL reset_pay32: got %h want 0", act32);
    end
    nvec++;
    if (act64 !== '0) begin
      nerr++; $display("FAIL reset_pay64: got %h want 0", act64);
    end
    @(negedge clk);
  endtask

  task automatic test_decode();
    exp_t e;
    offer(64'h100, 32'hFFF10093);
    e = model(64'h100, 32'hFFF10093, 32);
    nvec++;
    if (act32 !== e) begin
      nerr++; $display("FAIL addi_model: got %h want %h", act32, e);
    end
    nvec++;
    if ({v32, rd32, rs1_32, imm32, we32, a32, ill32, pc32} !==
        {1'b1, 5'd1, 5'd2, 32'hFFFFFFFF, 3'b110, 32'h100}) begin
      nerr++; $display("FAIL addi_fields: got rd=%0d rs1=%0d imm=%h",
                       rd32, rs1_32, imm32);
    end
    nvec++;
    if (imm64 !== 64'hFFFFFFFF_FFFFFFFF) begin
      nerr++; $display("FAIL addi_imm64: got %h want all-ones", imm64);
    end

    offer(64'h104, 32'h008000EF);
    e = model(64'h104, 32'h008000EF, 32);
    nvec++;
    if (act32 !== e) begin
      nerr++; $display("FAIL jal_model: got %h want %h", act32, e);
    end
    nvec++;
    if ({imm32, rd32, we32, a32, f3_32} !==
        {32'd8, 5'd1, 1'b1, 1'b0, 3'd0}) begin
      nerr++; $display("FAIL jal_fields: got imm=%h rd=%0d we=%b re1=%b",
                       imm32, rd32, we32, a32);
    end

    offer(64'h108, 32'h00000000);
    nvec++;
    if ({ill32, we32, a32, b32, imm32, ill64} !== {4'b1000, 32'h0, 1'b1}) begin
      nerr++; $display("FAIL zero_illegal: got ill=%b en=%b%b%b imm=%h",
                       ill32, we32, a32, b32, imm32);
    end

    offer(64'h10C, 32'h02009093);
    nvec++;
    if ({ill32, ill64, imm64[5:0]} !== {1'b1, 1'b0, 6'd32}) begin
      nerr++; $display("FAIL slli32: got ill32=%b ill64=%b sh=%0d",
                       ill32, ill64, imm64[5:0]);
    end
    e = model(64'h10C, 32'h02009093, 64);
    nvec++;
    if (act64 !== e) begin
      nerr++; $display("FAIL slli64_model: got %h want %h", act64, e);
    end

    offer(64'h110, 32'h022081B3);
    nvec++;
    if ({ill32, rd32, a32, b32} !== {!M_EN, 5'd3, M_EN, M_EN}) begin
      nerr++; $display("FAIL mul: got ill=%b rd=%0d re=%b%b want ill=%b",
                       ill32, rd32, a32, b32, !M_EN);
    end
    e = model(64'h110, 32'h022081B3, 32);
    nvec++;
    if (act32 !== e) begin
      nerr++; $display("FAIL mul_model: got %h want %h", act32, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bi [3];
    logic [63:0] bp [3];
    exp_t e;
    int k;
    bit drop;
    bi[0] = 32'h00500113; bi[1] = 32'h40208233; bi[2] = 32'h0041A023;
    bp[0] = 64'h200; bp[1] = 64'h204; bp[2] = 64'h208;
    drain();
    out_ready = 0;
    for (int n = 0; n < 3; n++) begin
      pc = bp[n]; inst = bi[n]; in_valid = 1;
      nvec++;
      if (r32 !== (n < 2)) begin
        nerr++; $display("FAIL b2b_ready%0d: got %b want %b", n, r32, n < 2);
      end
      @(negedge clk);
    end
    e = model(bp[0], bi[0], 32);
    nvec++;
    if ({r32, v32, act32} !== {1'b0, 1'b1, e}) begin
      nerr++; $display("FAIL b2b_hold: got r=%b v=%b %h want %h",
                       r32, v32, act32, e);
    end
    out_ready = 1;
    k = 0;
    drop = 0;
    for (int c = 0; c < 10; c++) begin
      if (drop) in_valid = 0;
      drop = in_valid && r32;
      if (v32) begin
        nvec++;
        if (k > 2) begin
          nerr++; $display("FAIL b2b_dup: got extra %h", act32);
        end else begin
          e = model(bp[k], bi[k], 32);
          if (act32 !== e) begin
            nerr++; $display("FAIL b2b_order%0d: got %h want %h", k, act32, e);
          end
        end
        k++;
      end
      @(negedge clk);
    end
    in_valid = 0;
    nvec++;
    if (k !== 3) begin
      nerr++; $display("FAIL b2b_count: got %0d want 3", k);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    drain();
    out_ready = 0;
    offer(64'h300, 32'h00100093);
    out_ready = 0;
    pc = 64'h304; inst = 32'h00200113; in_valid = 1;
    @(negedge clk);
    pc = 64'h308; inst = 32'h00300193; in_valid = 1; flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    nvec++;
    if ({v32, r32, v64, r64} !== 4'b0101) begin
      nerr++; $display("FAIL flush_full: got %b want 0101",
                       {v32, r32, v64, r64});
    end
    out_ready = 1;
    repeat (2) @(negedge clk);
    nvec++;
    if (v32 !== 1'b0) begin
      nerr++; $display("FAIL flush_ghost: got valid %b want 0", v32);
    end
    offer(64'h310, 32'h00400213);
    out_ready = 0;
    pc = 64'h314; inst = 32'h00500293; in_valid = 1; flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    nvec++;
    if ({v32, r32} !== 2'b01) begin
      nerr++; $display("FAIL flush_one: got %b want 01", {v32, r32});
    end
    offer(64'h318, 32'h00600313);
    e = model(64'h318, 32'h00600313, 32);
    nvec++;
    if ({v32, act32} !== {1'b1, e}) begin
      nerr++; $display("FAIL flush_next: got %b %h want %h", v32, act32, e);
    end
    drain();
  endtask

  task automatic test_random();
    item_t it;
    exp_t e;
    bit acc, pop;
    q.delete();
    for (int n = 0; n < 800; n++) begin
      nvec++;
      if ({v32, r32, v64, r64} !==
          {q.size() > 0, q.size() < 2, q.size() > 0, q.size() < 2}) begin
        nerr++; $display("FAIL rnd_hs@%0d: got %b want occupancy %0d",
                         n, {v32, r32, v64, r64}, q.size());
      end
      if (q.size() > 0) begin
        e = model(q[0].pc, q[0].inst, 32);
        nvec++;
        if (act32 !== e) begin
          nerr++; $display("FAIL rnd32@%0d: got %h want %h", n, act32, e);
        end
        e = model(q[0].pc, q[0].inst, 64);
        nvec++;
        if (act64 !== e) begin
          nerr++; $display("FAIL rnd64@%0d: got %h want %h", n, act64, e);
        end
      end
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      pc = {$urandom, $urandom & 32'hFFFFFFFC};
      inst = rnd_inst();
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          it.pc = pc; it.inst = inst;
          q.push_back(it);
        end
      end
      @(negedge clk);
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    pc = '0; inst = '0;
    @(negedge clk);
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
